multicycle_ctrl: RTL

Sequencing controller for the multicycle CPU datapath. It replaces the free-running control FSM with a handshaked one. It walks each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath enable and mux select. It stalls on a shared memory ready/request handshake, traps on illegal opcodes or memory timeouts, and counts retired instructions. It sits between the decoder outputs (opcode, funct) and the register, regfile, ALU, memory and PC-select blocks in `cpu`.

---
 rtl/multicycle_ctrl.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Handshaked sequencing controller for the multicycle CPU datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready, traps on faults, counts retirements.
module multicycle_ctrl #(
    parameter int unsigned COUNT_W     = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               instrReg,
    output logic               R_rsReg,
    output logic               R_rtReg,
    output logic               PCReg,
    output logic               RegWr,
    output logic               MemWr,
    output logic               ALUSrc,
    output logic [2:0]         ALUcntrl,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemToReg,
    output logic               jump,
    output logic               beq,
    output logic               bne,
    output logic               addrGen,
    output logic [2:0]         state,
    output logic               trap,
    output logic [COUNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_e;

    // Instruction class latched in DECODE so later states do not depend on the decoder inputs.
    typedef enum logic [2:0] {
        K_ALU = 3'd0,
        K_LW  = 3'd1,
        K_SW  = 3'd2,
        K_BEQ = 3'd3,
        K_BNE = 3'd4,
        K_JMP = 3'd5,
        K_JAL = 3'd6
    } kind_e;

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d;
    logic [2:0]          alu_q, alu_d;
    logic                src_q, src_d;
    logic [1:0]          dst_q, dst_d;
    logic [1:0]          m2r_q, m2r_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [COUNT_W-1:0]  retired_q;

    logic                dec_ok;
    kind_e               dec_kind;
    logic [2:0]          dec_alu;
    logic                dec_src;
    logic [1:0]          dec_dst;
    logic [1:0]          dec_m2r;
    logic                timeout_c;
    logic                sel_on_c;

    // Opcode/funct decode table.
    always_comb begin
        dec_ok   = 1'b1;
        dec_kind = K_ALU;
        dec_alu  = ALU_ADD;
        dec_src  = 1'b0;
        dec_dst  = 2'd0;
        dec_m2r  = 2'd0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec_alu = ALU_ADD;
                    FN_SUB:  dec_alu = ALU_SUB;
                    FN_SLT:  dec_alu = ALU_SLT;
                    FN_JR:   dec_kind = K_JMP;
                    default: dec_ok = 1'b0;
                endcase
            end
            OP_ADDI: begin
                dec_src = 1'b1;
                dec_dst = 2'd2;
            end
            OP_XORI: begin
                dec_alu = ALU_XOR;
                dec_src = 1'b1;
                dec_dst = 2'd2;
            end
            OP_LW: begin
                dec_kind = K_LW;
                dec_src  = 1'b1;
                dec_dst  = 2'd2;
                dec_m2r  = 2'd1;
            end
            OP_SW: begin
                dec_kind = K_SW;
                dec_src  = 1'b1;
            end
            OP_BEQ: begin
                dec_kind = K_BEQ;
                dec_alu  = ALU_SUB;
            end
            OP_BNE: begin
                dec_kind = K_BNE;
                dec_alu  = ALU_SUB;
            end
            OP_J: begin
                dec_kind = K_JMP;
                dec_dst  = 2'd1;
                dec_m2r  = 2'd2;
            end
            OP_JAL: begin
                dec_kind = K_JAL;
                dec_dst  = 2'd1;
                dec_m2r  = 2'd2;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // The wait counter holds prior stall cycles, so the MEM_TIMEOUT-th stall cycle decides the trap.
    assign timeout_c = (MEM_TIMEOUT != 0) && !mem_ready
                       && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        alu_d    = alu_q;
        src_d    = src_q;
        dst_d    = dst_q;
        m2r_d    = m2r_q;
        mem_req  = 1'b0;
        instrReg = 1'b0;
        R_rsReg  = 1'b0;
        R_rtReg  = 1'b0;
        PCReg    = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        jump     = 1'b0;
        beq      = 1'b0;
        bne      = 1'b0;
        addrGen  = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    instrReg = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_c) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                R_rsReg = 1'b1;
                R_rtReg = 1'b1;
                addrGen = 1'b1;
                kind_d  = dec_kind;
                alu_d   = dec_alu;
                src_d   = dec_src;
                dst_d   = dec_dst;
                m2r_d   = dec_m2r;
                state_d = dec_ok ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (kind_q)
                    K_BEQ: begin
                        beq     = 1'b1;
                        PCReg   = 1'b1;
                        state_d = S_FETCH;
                    end
                    K_BNE: begin
                        bne     = 1'b1;
                        PCReg   = 1'b1;
                        state_d = S_FETCH;
                    end
                    K_JMP: begin
                        jump    = 1'b1;
                        PCReg   = 1'b1;
                        state_d = S_FETCH;
                    end
                    K_JAL: begin
                        jump    = 1'b1;
                        PCReg   = 1'b1;
                        RegWr   = 1'b1;
                        state_d = S_FETCH;
                    end
                    K_LW, K_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                MemWr   = (kind_q == K_SW);
                if (mem_ready) begin
                    if (kind_q == K_SW) begin
                        PCReg   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_c) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                RegWr   = 1'b1;
                PCReg   = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if ((MEM_TIMEOUT != 0) && !mem_ready
                     && (state_q == S_FETCH || state_q == S_MEM)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_BOOT;
            kind_q    <= K_ALU;
            alu_q     <= '0;
            src_q     <= 1'b0;
            dst_q     <= '0;
            m2r_q     <= '0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            alu_q   <= alu_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            m2r_q   <= m2r_d;
            wait_q  <= wait_d;
            if (PCReg) begin
                retired_q <= retired_q + COUNT_W'(1);
            end
        end
    end

    // Selects are forced low in BOOT and TRAP so those states present an all-zero datapath.
    assign sel_on_c = (state_q != S_BOOT) && (state_q != S_TRAP);
    assign ALUcntrl = sel_on_c ? alu_q : 3'd0;
    assign ALUSrc   = sel_on_c && src_q;
    assign RegDst   = sel_on_c ? dst_q : 2'd0;
    assign MemToReg = sel_on_c ? m2r_q : 2'd0;
    assign state    = 3'(state_q);
    assign trap     = (state_q == S_TRAP);
    assign retired  = retired_q;

endmodule
